// File: rtl/m_spi_control.sv
// m_spi_control: mode-0 SPI master (initiator).
// SCLK idles low. Data is sampled on the SCLK rise and changed on the fall.
// SS is active low. Data is sent MSB first, with one word per SS frame.
//
// Frame sequence after start is accepted:
//   SETUP -> XFER (DATA_LENGTH SCLK periods) -> HOLD -> GAP -> IDLE.
// SETUP, each SCLK half-period, HOLD and GAP each last CLK_DIV clk cycles.
//
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   i_start            transfer request, sampled only in IDLE
//   i_tx_data          word to send, captured when start is accepted
//   o_rx_data          received word, updated together with o_done
//   o_busy             high from accept+1 until the end of GAP
//   o_done             one-cycle pulse when SS rises
//   SCLK, MOSI, SS     SPI outputs (all registered)
//   MISO               SPI input
//
// Build option: define M_SPI_LOOPBACK_EN to make the rx path sample the
// internal MOSI register instead of the MISO pin (self-test).
module m_spi_control #(
  parameter int DATA_LENGTH = 8,
  parameter int CLK_DIV     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [DATA_LENGTH-1:0] i_tx_data,
  output logic [DATA_LENGTH-1:0] o_rx_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   SCLK,
  output logic                   MOSI,
  input  logic                   MISO,
  output logic                   SS
);

  localparam int BW = $clog2(DATA_LENGTH) + 1;
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_LENGTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t                 state, state_nxt;
  logic [DW-1:0]          div_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_LENGTH-1:0] tx_sh;
  logic [DATA_LENGTH-1:0] rx_sh;
  logic                   tick;
  logic                   rx_bit;

  // The divider runs in every non-IDLE state. tick marks the last cycle of
  // each CLK_DIV-long phase or half-period.
  assign tick = (div_cnt == DIV_LAST);

`ifdef M_SPI_LOOPBACK_EN
  // MISO is intentionally unused in loopback builds.
  logic unused_miso;
  assign unused_miso = MISO;
  assign rx_bit      = MOSI;
`else
  assign rx_bit      = MISO;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = SETUP;
      SETUP:   if (tick)    state_nxt = XFER;
      // Leave XFER on the falling edge of the last SCLK period.
      XFER:    if (tick && SCLK && bit_cnt == BIT_LAST) state_nxt = HOLD;
      HOLD:    if (tick)    state_nxt = GAP;
      GAP:     if (tick)    state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      o_rx_data <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      SS        <= 1'b1;
    end else begin
      o_done <= 1'b0;
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (i_start) begin
            tx_sh  <= i_tx_data;
            MOSI   <= i_tx_data[DATA_LENGTH-1];
            SS     <= 1'b0;
            o_busy <= 1'b1;
          end
        end
        XFER: begin
          if (tick) begin
            SCLK <= ~SCLK;
            if (!SCLK) begin
              rx_sh <= {rx_sh[DATA_LENGTH-2:0], rx_bit};
            end else if (bit_cnt == BIT_LAST) begin
              // MOSI holds the last bit through HOLD.
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_sh   <= {tx_sh[DATA_LENGTH-2:0], 1'b0};
              MOSI    <= tx_sh[DATA_LENGTH-2];
            end
          end
        end
        HOLD: begin
          if (tick) begin
            SS        <= 1'b1;
            o_rx_data <= rx_sh;
            o_done    <= 1'b1;
          end
        end
        GAP: begin
          if (tick) o_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_spi_control.sv
// Directed testbench for m_spi_control.
// dut0 uses the default parameters (8 bits, CLK_DIV=4).
// dut1 uses CLK_DIV=1.
// Each DUT is connected to a behavioural mode-0 slave that shifts out a
// reply word and logs every word it receives.
module tb_m_spi_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] tx0 = 8'h00, tx1 = 8'h00;
  logic [7:0] rx0, rx1;
  logic       busy0, busy1, done0, done1;
  logic       SCLK0, SCLK1, MOSI0, MOSI1, MISO0, MISO1, SS0, SS1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_spi_control #(.DATA_LENGTH(8), .CLK_DIV(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(start0), .i_tx_data(tx0),
    .o_rx_data(rx0), .o_busy(busy0), .o_done(done0),
    .SCLK(SCLK0), .MOSI(MOSI0), .MISO(MISO0), .SS(SS0)
  );

  m_spi_control #(.DATA_LENGTH(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_tx_data(tx1),
    .o_rx_data(rx1), .o_busy(busy1), .o_done(done1),
    .SCLK(SCLK1), .MOSI(MOSI1), .MISO(MISO1), .SS(SS1)
  );

  // ---------------- slave models ----------------
  logic [7:0] s0_reply = 8'h00, s0_sh = 8'h00, s0_rcv = 8'h00;
  logic [7:0] s1_reply = 8'h00, s1_sh = 8'h00, s1_rcv = 8'h00;
  logic [7:0] s0_log[$];
  logic [7:0] s1_log[$];

  assign MISO0 = s0_sh[7];
  assign MISO1 = s1_sh[7];

  always begin
    @(negedge SS0);
    s0_sh  = s0_reply;
    s0_rcv = 8'h00;
    while (SS0 == 1'b0) begin
      @(posedge SCLK0 or posedge SS0);
      if (SS0) break;
      s0_rcv = {s0_rcv[6:0], MOSI0};
      @(negedge SCLK0 or posedge SS0);
      if (SS0) break;
      s0_sh = s0_sh << 1;
    end
    s0_log.push_back(s0_rcv);
  end

  always begin
    @(negedge SS1);
    s1_sh  = s1_reply;
    s1_rcv = 8'h00;
    while (SS1 == 1'b0) begin
      @(posedge SCLK1 or posedge SS1);
      if (SS1) break;
      s1_rcv = {s1_rcv[6:0], MOSI1};
      @(negedge SCLK1 or posedge SS1);
      if (SS1) break;
      s1_sh = s1_sh << 1;
    end
    s1_log.push_back(s1_rcv);
  end

  // ---------------- dut0 frame monitor (sampled on negedge) ----------------
  int   cyc = 0;
  int   low0 = 0, low0_last = 0, high0 = 0, gap0_last = 0, rises0 = 0;
  int   done_cnt0 = 0, done_cyc0 = 0, bfall_cyc0 = 0, viol = 0;
  logic [7:0] rx_at_done0 = 8'h00;
  logic p_ss0 = 1'b1, p_sclk0 = 1'b0, p_busy0 = 1'b0, p_mosi0 = 1'b0, p_mosi1 = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!SS0 && p_ss0) begin low0 = 1; rises0 = 0; gap0_last = high0; end
    else if (!SS0) low0 = low0 + 1;
    if (SS0 && !p_ss0) begin low0_last = low0; high0 = 1; end
    else if (SS0) high0 = high0 + 1;
    if (SCLK0 && !p_sclk0) rises0 = rises0 + 1;
    if (done0) begin done_cnt0 = done_cnt0 + 1; rx_at_done0 = rx0; done_cyc0 = cyc; end
    if (!busy0 && p_busy0) bfall_cyc0 = cyc;
    // MOSI must not change while SCLK is high; SCLK never high with SS high.
    if (SCLK0 && MOSI0 !== p_mosi0) viol = viol + 1;
    if (SCLK1 && MOSI1 !== p_mosi1) viol = viol + 1;
    if (SCLK0 && SS0) viol = viol + 1;
    if (SCLK1 && SS1) viol = viol + 1;
    p_ss0 = SS0; p_sclk0 = SCLK0; p_busy0 = busy0; p_mosi0 = MOSI0; p_mosi1 = MOSI1;
  end

  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] rep);
`ifdef M_SPI_LOOPBACK_EN
    exp_rx = tx;
`else
    exp_rx = rep;
`endif
  endfunction

  // ---------------- helpers ----------------
  task automatic go0(input logic [7:0] tx);
    @(negedge clk); tx0 = tx; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
  endtask

  task automatic wait_idle0(input string nm);
    int n;
    n = 0;
    while (busy0 !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n >= 400) begin errors++; $display("FAIL %s_timeout: busy still high after 400 cycles", nm); end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (SS0 !== 1'b1)     begin errors++; $display("FAIL reset_ss: got %b want 1", SS0); end
    checks++; if (SCLK0 !== 1'b0)   begin errors++; $display("FAIL reset_sclk: got %b want 0", SCLK0); end
    checks++; if (MOSI0 !== 1'b0)   begin errors++; $display("FAIL reset_mosi: got %b want 0", MOSI0); end
    checks++; if (busy0 !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done0); end
    checks++; if (rx0 !== 8'h00)    begin errors++; $display("FAIL reset_rx: got %h want 00", rx0); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int d;
    s0_reply = 8'h3C; s0_log.delete(); d = done_cnt0;
    go0(8'hA5);
    wait_idle0("basic");
    checks++; if (rx0 !== exp_rx(8'hA5, 8'h3C)) begin errors++; $display("FAIL basic_rx: got %h want %h", rx0, exp_rx(8'hA5, 8'h3C)); end
    checks++; if (rx_at_done0 !== exp_rx(8'hA5, 8'h3C)) begin errors++; $display("FAIL basic_rx_at_done: got %h want %h", rx_at_done0, exp_rx(8'hA5, 8'h3C)); end
    checks++; if (done_cnt0 - d !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt0 - d); end
    checks++; if (s0_log.size() !== 1 || s0_log[0] !== 8'hA5) begin errors++; $display("FAIL basic_slave_rx: got %0d words first %h want 1 word a5", s0_log.size(), (s0_log.size() > 0) ? s0_log[0] : 8'h00); end
    checks++; if (low0_last !== 72) begin errors++; $display("FAIL basic_ss_low: got %0d want 72", low0_last); end
    checks++; if (rises0 !== 8) begin errors++; $display("FAIL basic_sclk_rises: got %0d want 8", rises0); end
    checks++; if (bfall_cyc0 - done_cyc0 !== 4) begin errors++; $display("FAIL basic_busy_fall: got %0d want 4", bfall_cyc0 - done_cyc0); end
  endtask

  task automatic test_back_to_back();
    int d, n;
    s0_reply = 8'h77; s0_log.delete(); d = done_cnt0;
    @(negedge clk); tx0 = 8'h01; start0 = 1'b1;
    @(negedge clk); tx0 = 8'hFE;
    n = 0;
    while (busy0 !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    checks++; if (n >= 400) begin errors++; $display("FAIL b2b_timeout: first frame did not end"); end
    @(negedge clk); start0 = 1'b0;
    checks++; if (SS0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL b2b_restart: got ss=%b busy=%b want ss=0 busy=1", SS0, busy0); end
    wait_idle0("b2b");
    checks++; if (s0_log.size() !== 2 || s0_log[0] !== 8'h01 || s0_log[1] !== 8'hFE) begin errors++; $display("FAIL b2b_slave_rx: got %0d words want 01 then fe", s0_log.size()); end
    checks++; if (gap0_last !== 5) begin errors++; $display("FAIL b2b_ss_gap: got %0d want 5", gap0_last); end
    checks++; if (done_cnt0 - d !== 2) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt0 - d); end
    checks++; if (rx0 !== exp_rx(8'hFE, 8'h77)) begin errors++; $display("FAIL b2b_rx: got %h want %h", rx0, exp_rx(8'hFE, 8'h77)); end
  endtask

  task automatic test_ignore_start();
    int d;
    s0_reply = 8'hE1; s0_log.delete(); d = done_cnt0;
    go0(8'h0F);
    repeat (20) @(negedge clk);
    checks++; if (SS0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL ign_in_xfer: got ss=%b busy=%b want 0 1", SS0, busy0); end
    tx0 = 8'h55; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    wait_idle0("ign");
    repeat (100) @(negedge clk);
    checks++; if (done_cnt0 - d !== 1) begin errors++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt0 - d); end
    checks++; if (busy0 !== 1'b0 || SS0 !== 1'b1) begin errors++; $display("FAIL ign_idle: got busy=%b ss=%b want 0 1", busy0, SS0); end
    checks++; if (s0_log.size() !== 1 || s0_log[0] !== 8'h0F) begin errors++; $display("FAIL ign_slave_rx: got %0d words want one 0f", s0_log.size()); end
    checks++; if (rx0 !== exp_rx(8'h0F, 8'hE1)) begin errors++; $display("FAIL ign_rx: got %h want %h", rx0, exp_rx(8'h0F, 8'hE1)); end
  endtask

  task automatic test_reset_mid();
    int d, n, r;
    logic ps;
    s0_reply = 8'h5A; d = done_cnt0;
    go0(8'hF0);
    n = 0; r = 0; ps = SCLK0;
    while (r < 4 && n < 300) begin
      @(posedge clk); #1;
      if (SCLK0 && !ps) r++;
      ps = SCLK0; n++;
    end
    checks++; if (r < 4) begin errors++; $display("FAIL rstmid_timeout: saw %0d rises want 4", r); end
    rst_n = 1'b0; #1;
    checks++; if (SS0 !== 1'b1)   begin errors++; $display("FAIL rstmid_ss: got %b want 1", SS0); end
    checks++; if (SCLK0 !== 1'b0) begin errors++; $display("FAIL rstmid_sclk: got %b want 0", SCLK0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done0); end
    checks++; if (rx0 !== 8'h00)  begin errors++; $display("FAIL rstmid_rx: got %h want 00", rx0); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (done_cnt0 !== d) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt0 - d); end
    s0_log.delete(); s0_reply = 8'h42;
    go0(8'h81);
    wait_idle0("rstmid");
    checks++; if (rx0 !== exp_rx(8'h81, 8'h42)) begin errors++; $display("FAIL rstmid_rx_after: got %h want %h", rx0, exp_rx(8'h81, 8'h42)); end
    checks++; if (s0_log.size() !== 1 || s0_log[0] !== 8'h81) begin errors++; $display("FAIL rstmid_slave_rx: got %0d words want one 81", s0_log.size()); end
    checks++; if (low0_last !== 72) begin errors++; $display("FAIL rstmid_ss_low: got %0d want 72", low0_last); end
  endtask

  task automatic test_div1();
    int low, n;
    s1_reply = 8'h96; s1_log.delete();
    @(negedge clk); tx1 = 8'hC3; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    low = 0; n = 0;
    while (busy1 !== 1'b0 && n < 200) begin
      if (!SS1) low++;
      @(negedge clk); n++;
    end
    checks++; if (n >= 200) begin errors++; $display("FAIL div1_timeout: busy still high"); end
    repeat (2) @(negedge clk);
    checks++; if (low !== 18) begin errors++; $display("FAIL div1_ss_low: got %0d want 18", low); end
    checks++; if (rx1 !== exp_rx(8'hC3, 8'h96)) begin errors++; $display("FAIL div1_rx: got %h want %h", rx1, exp_rx(8'hC3, 8'h96)); end
    checks++; if (s1_log.size() !== 1 || s1_log[0] !== 8'hC3) begin errors++; $display("FAIL div1_slave_rx: got %0d words want one c3", s1_log.size()); end
  endtask

`ifdef M_SPI_LOOPBACK_EN
  task automatic test_loopback();
    s0_reply = 8'h00;
    go0(8'h6B);
    wait_idle0("loopback");
    checks++; if (rx0 !== 8'h6B) begin errors++; $display("FAIL loopback_rx: got %h want 6b", rx0); end
  endtask
`endif

  task automatic test_protocol();
    checks++; if (viol !== 0) begin errors++; $display("FAIL protocol: got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_div1();
`ifdef M_SPI_LOOPBACK_EN
    test_loopback();
`endif
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
